// File: rtl/seq_det_pkg.sv
// Shared encoding and defaults for the time-shared "101" sequence detector.
package seq_det_pkg;

    localparam int NCH_DEF   = 4;
    localparam int CNT_W_DEF = 8;
    // Pointer is sized for the largest supported channel count (8).
    localparam int PTR_W     = 3;

    localparam logic [1:0] ST_A = 2'b00;
    localparam logic [1:0] ST_B = 2'b01;
    localparam logic [1:0] ST_C = 2'b10;
    localparam logic [1:0] ST_D = 2'b11;

    // Non-overlapping Moore "101": leaving D restarts the search from scratch.
    function automatic logic [1:0] ns_101(input logic [1:0] s, input logic b);
        logic [1:0] n;
        case (s)
            ST_A:    n = b ? ST_B : ST_A;
            ST_B:    n = b ? ST_B : ST_C;
            ST_C:    n = b ? ST_D : ST_A;
            default: n = b ? ST_B : ST_A;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr, wrapping.
module rr_arbiter
    import seq_det_pkg::*;
#(
    parameter int NCH = NCH_DEF
) (
    input  logic [NCH-1:0]   req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NCH-1:0]   gnt
);

    logic [2*NCH-1:0] req_dbl;
    logic [2*NCH-1:0] gnt_dbl;
    logic [NCH-1:0]   rot;
    logic [NCH-1:0]   pick;
    logic             found;

    // Rotate so ptr sits at bit 0, pick the lowest set bit, rotate back.
    always_comb begin
        req_dbl = {req, req} >> ptr;
        rot     = req_dbl[NCH-1:0];
        pick    = '0;
        found   = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (!found && rot[i]) begin
                pick[i] = 1'b1;
                found   = 1'b1;
            end
        end
        gnt_dbl = {{NCH{1'b0}}, pick} << ptr;
        gnt     = gnt_dbl[NCH-1:0] | gnt_dbl[2*NCH-1:NCH];
    end

endmodule

// File: rtl/seq_det_scheduler.sv
// Multi-channel "101" detector sharing one next-state function across channels
// through a round-robin grant; per-channel 2-bit contexts live here.
module seq_det_scheduler
    import seq_det_pkg::*;
#(
    parameter int NCH   = NCH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic [NCH-1:0]     x_valid,
    input  logic [NCH-1:0]     x,
    output logic [NCH-1:0]     ready,
    output logic [NCH-1:0]     hit,
    output logic [NCH-1:0]     det,
    output logic [CNT_W-1:0]   hit_count,
    output logic [2*NCH-1:0]   dbg_ctx,
    output logic [PTR_W-1:0]   dbg_ptr
);

    logic [1:0]       ctx_q [NCH];
    logic [1:0]       ctx_d [NCH];
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [NCH-1:0]   hit_q, hit_d;
    logic [NCH-1:0]   det_q, det_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [NCH-1:0]   gnt;
    logic             xfer;
    logic [PTR_W-1:0] sel;
    logic [1:0]       sel_ctx;
    logic             sel_bit;
    logic [1:0]       sel_ns;

    rr_arbiter #(.NCH(NCH)) u_arb (
        .req (x_valid),
        .ptr (ptr_q),
        .gnt (gnt)
    );

    // Handshake: bit x[i] is consumed at a rising edge iff x_valid[i] && ready[i];
    // ready never rises without x_valid, is at most one-hot, and is zero during clear.
    assign ready = clear ? '0 : gnt;

    always_comb begin
        xfer    = |ready;
        sel     = '0;
        sel_ctx = ST_A;
        sel_bit = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (ready[i]) begin
                sel     = PTR_W'(i);
                sel_ctx = ctx_q[i];
                sel_bit = x[i];
            end
        end
        sel_ns = ns_101(sel_ctx, sel_bit);
    end

    always_comb begin
        ptr_d = ptr_q;
        hit_d = '0;
        cnt_d = cnt_q;
        for (int i = 0; i < NCH; i++) begin
            ctx_d[i] = ctx_q[i];
        end
        if (clear) begin
            for (int i = 0; i < NCH; i++) begin
                ctx_d[i] = ST_A;
            end
            ptr_d = '0;
            cnt_d = '0;
        end else if (xfer) begin
            for (int i = 0; i < NCH; i++) begin
                if (ready[i]) begin
                    ctx_d[i] = sel_ns;
                    hit_d[i] = (sel_ns == ST_D);
                end
            end
            ptr_d = (sel == PTR_W'(NCH - 1)) ? '0 : sel + PTR_W'(1);
            if (|hit_d && cnt_q != '1) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        for (int i = 0; i < NCH; i++) begin
            det_d[i] = (ctx_d[i] == ST_D);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NCH; i++) begin
                ctx_q[i] <= ST_A;
            end
            ptr_q <= '0;
            hit_q <= '0;
            det_q <= '0;
            cnt_q <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                ctx_q[i] <= ctx_d[i];
            end
            ptr_q <= ptr_d;
            hit_q <= hit_d;
            det_q <= det_d;
            cnt_q <= cnt_d;
        end
    end

    assign hit       = hit_q;
    assign det       = det_q;
    assign hit_count = cnt_q;
    assign dbg_ptr   = ptr_q;

    for (genvar g = 0; g < NCH; g++) begin : g_dbg
        assign dbg_ctx[2*g +: 2] = ctx_q[g];
    end

endmodule
